sram_read_sequencer: RTL and testbench

- Upstream driver and downstream consumer for the 128-bit SRAM/BRAM read port.
- Sweeps read addresses 0..ADDR_LAST, pulses the read strobe, and captures each 128-bit word when the port flags it valid.
- Serialises each captured word into bytes over a valid/ready stream feeding the UART/host readout path.
- One clock domain; the sweep is launched by a single start pulse.

---
 rtl/sram_read_sequencer.sv | 175 +++++++++++++++++
 tb/tb_sram_read_sequencer.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_read_sequencer.sv
// sram_read_sequencer
// Sweeps the SRAM read port over addresses 0..ADDR_LAST, captures each
// DATA_W-bit word when the port flags it valid, and streams it out LSB byte
// first over a valid/ready byte interface.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   start                 one-cycle pulse, launches a sweep when idle
//   addr_cntrl, Din_valid read address and read strobe to the SRAM port
//   Dout, Dout_valid      read data and its valid flag from the SRAM port
//   byte_data, byte_valid serialised byte stream to the readout path
//   byte_ready            downstream accept
//   busy, done, err       sweep in progress, end-of-sweep pulse, sticky timeout
module sram_read_sequencer #(
    parameter int unsigned ADDR_W    = 7,
    parameter int unsigned DATA_W    = 128,
    parameter int unsigned ADDR_LAST = 127,
    parameter int unsigned TIMEOUT   = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [ADDR_W-1:0] addr_cntrl,
    output logic              Din_valid,
    input  logic [DATA_W-1:0] Dout,
    input  logic              Dout_valid,
    output logic [7:0]        byte_data,
    output logic              byte_valid,
    input  logic              byte_ready,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int unsigned N_BYTES = DATA_W / 8;
    localparam int unsigned BIDX_W  = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
    localparam int unsigned WAIT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_SHIFT = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-1:0]   r_addr;
    logic [WAIT_W-1:0]   r_wait;
    logic [DATA_W-1:0]   r_word;
    logic [BIDX_W-1:0]   r_bidx;
    logic                r_err;
    logic                r_din_valid;
    logic                r_byte_valid;
    logic                r_busy;
    logic                r_done;

    logic                w_capture;
    logic                w_timeout;
    logic                w_hs;
    logic                w_last;
    logic                w_at_last_addr;

    assign w_at_last_addr = (r_addr == ADDR_W'(ADDR_LAST));

    // Next-state and per-cycle control decode
    always_comb begin
        w_next    = r_state;
        w_capture = 1'b0;
        w_timeout = 1'b0;
        w_hs      = 1'b0;
        w_last    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_next = S_ISSUE;
            end
            S_ISSUE: begin
                if (Dout_valid) begin
                    w_capture = 1'b1;
                    w_next    = S_SHIFT;
                end else begin
                    w_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (Dout_valid) begin
                    w_capture = 1'b1;
                    w_next    = S_SHIFT;
                end else if (r_wait == WAIT_W'(TIMEOUT)) begin
                    w_timeout = 1'b1;
                    w_next    = S_SHIFT;
                end
            end
            S_SHIFT: begin
                // byte_valid is high for the whole of SHIFT, so ready alone
                // marks the handshake
                w_hs = byte_ready;
                if (byte_ready && (r_bidx == BIDX_W'(N_BYTES - 1))) begin
                    w_last = 1'b1;
                    w_next = w_at_last_addr ? S_DONE : S_ISSUE;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_addr       <= '0;
            r_wait       <= '0;
            r_word       <= '0;
            r_bidx       <= '0;
            r_err        <= 1'b0;
            r_din_valid  <= 1'b0;
            r_byte_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_next;
            // Status flags are decoded from the next state so they line up
            // with the state they describe
            r_din_valid  <= (w_next == S_ISSUE);
            r_byte_valid <= (w_next == S_SHIFT);
            r_busy       <= (w_next == S_ISSUE) || (w_next == S_WAIT) ||
                            (w_next == S_SHIFT);
            r_done       <= (w_next == S_DONE);

            if ((r_state == S_IDLE) && start) begin
                r_addr <= '0;
                r_err  <= 1'b0;
            end

            if (r_state == S_ISSUE) begin
                r_wait <= '0;
            end else if ((r_state == S_WAIT) && !Dout_valid && !w_timeout) begin
                r_wait <= r_wait + WAIT_W'(1);
            end

            // The word register shifts right on each handshake, so the byte
            // on offer is always its low byte (byte 0 first)
            if (w_capture) begin
                r_word <= Dout;
                r_bidx <= '0;
            end else if (w_timeout) begin
                r_word <= '0;
                r_bidx <= '0;
                r_err  <= 1'b1;
            end else if (w_hs) begin
                r_word <= {8'h00, r_word[DATA_W-1:8]};
                r_bidx <= w_last ? '0 : r_bidx + BIDX_W'(1);
            end

            if (w_last && !w_at_last_addr) begin
                r_addr <= r_addr + ADDR_W'(1);
            end
        end
    end

    assign addr_cntrl = r_addr;
    assign Din_valid  = r_din_valid;
    assign byte_data  = r_word[7:0];
    assign byte_valid = r_byte_valid;
    assign busy       = r_busy;
    assign done       = r_done;
    assign err        = r_err;

endmodule

// File: tb/tb_sram_read_sequencer.sv
// Testbench for sram_read_sequencer: randomised SRAM latency, byte-order,
// backpressure, timeout, mid-sweep reset and a short-sweep instance, all
// checked against an expected byte queue built from the memory image.
module tb_sram_read_sequencer;

    localparam int unsigned ADDR_W = 7;
    localparam int unsigned DATA_W = 128;
    localparam int N_ADDR = 128;
    localparam int NB     = 16;
    localparam int NEVER  = 255;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic              start;
    logic [ADDR_W-1:0] addr_cntrl;
    logic              Din_valid;
    logic [DATA_W-1:0] Dout;
    logic              Dout_valid;
    logic [7:0]        byte_data;
    logic              byte_valid;
    logic              byte_ready;
    logic              busy, done, err;

    logic              start_s;
    logic [ADDR_W-1:0] addr_s;
    logic              din_valid_s;
    logic [DATA_W-1:0] dout_s;
    logic              dout_valid_s;
    logic [7:0]        byte_data_s;
    logic              byte_valid_s;
    logic              byte_ready_s;
    logic              busy_s, done_s, err_s;

    sram_read_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ADDR_LAST(127), .TIMEOUT(15)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .addr_cntrl(addr_cntrl), .Din_valid(Din_valid),
        .Dout(Dout), .Dout_valid(Dout_valid),
        .byte_data(byte_data), .byte_valid(byte_valid), .byte_ready(byte_ready),
        .busy(busy), .done(done), .err(err)
    );

    sram_read_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ADDR_LAST(3), .TIMEOUT(15)) u_short (
        .clk(clk), .rst_n(rst_n), .start(start_s),
        .addr_cntrl(addr_s), .Din_valid(din_valid_s),
        .Dout(dout_s), .Dout_valid(dout_valid_s),
        .byte_data(byte_data_s), .byte_valid(byte_valid_s), .byte_ready(byte_ready_s),
        .busy(busy_s), .done(done_s), .err(err_s)
    );

    // SRAM model: per-address latency (0 = same cycle, NEVER = no response)
    logic [DATA_W-1:0] mem [N_ADDR];
    int                lat [N_ADDR];
    int                lat_cur;
    logic              pend = 1'b0;
    int                cnt = 0;
    logic [DATA_W-1:0] junk = '0;
    logic              stray = 1'b0;
    logic              stray_en = 1'b0;

    always_comb begin
        lat_cur = lat[addr_cntrl];
        if (Din_valid)  Dout_valid = (lat_cur == 0);
        else if (pend)  Dout_valid = (cnt == lat_cur);
        else            Dout_valid = stray;
        Dout = (Din_valid || pend) && Dout_valid ? mem[addr_cntrl] : junk;
    end

    always @(posedge clk) begin
        junk  <= {$urandom, $urandom, $urandom, $urandom};
        stray <= stray_en && ($urandom_range(0, 3) == 0);
        if (Din_valid) begin
            pend <= (lat_cur != 0);
            cnt  <= 1;
        end else if (pend) begin
            if (cnt == lat_cur) pend <= 1'b0;
            cnt <= cnt + 1;
        end
    end

    logic [7:0] s_pat;
    always_comb begin
        s_pat        = 8'(addr_s) + 8'h10;
        dout_valid_s = din_valid_s;
        dout_s       = din_valid_s ? {NB{s_pat}} : '0;
    end
    assign byte_ready_s = 1'b1;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Checking and reference-model state
    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] byte_q [$];
    int         exp_addr, first_issue, done_cnt, done_cyc, n_bytes;
    logic       exp_err;
    logic       prev_stall;
    logic [7:0] prev_data;
    int         ready_mode, ready_ph;
    int         s_cnt, s_done, s_exp_addr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock: observe at the falling edge, drive just after the rising edge
    task automatic cycle();
        logic [7:0] eb;
        @(negedge clk);
        if (Din_valid) begin
            chk("issue_addr", 32'(addr_cntrl), 32'(exp_addr));
            if (first_issue < 0) first_issue = cyc;
            exp_addr++;
        end
        if (prev_stall) begin
            chk("stall_valid", 32'(byte_valid), 32'd1);
            chk("stall_data", 32'(byte_data), 32'(prev_data));
        end
        if (byte_valid && byte_ready) begin
            if (byte_q.size() == 0) begin
                chk("extra_byte", 32'(byte_q.size()), 32'd1);
            end else begin
                eb = byte_q.pop_front();
                chk("byte", 32'(byte_data), 32'(eb));
            end
            n_bytes++;
        end
        prev_stall = byte_valid && !byte_ready;
        prev_data  = byte_data;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            chk("err_at_done", 32'(err), 32'(exp_err));
        end
        if (din_valid_s) begin
            chk("short_addr", 32'(addr_s), 32'(s_exp_addr));
            s_exp_addr++;
        end
        if (byte_valid_s) begin
            chk("short_byte", 32'(byte_data_s), 32'(8'h10 + 8'(s_cnt / NB)));
            s_cnt++;
        end
        if (done_s) s_done++;
        @(posedge clk);
        #1;
        case (ready_mode)
            0:       byte_ready = 1'b1;
            1:       begin byte_ready = ((ready_ph % 4) == 0) || ((ready_ph % 4) == 3); ready_ph++; end
            default: byte_ready = 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_addr"},  32'(addr_cntrl), 32'd0);
        chk({tag, "_dinv"},  32'(Din_valid),  32'd0);
        chk({tag, "_bdata"}, 32'(byte_data),  32'd0);
        chk({tag, "_bvalid"},32'(byte_valid), 32'd0);
        chk({tag, "_busy"},  32'(busy),       32'd0);
        chk({tag, "_done"},  32'(done),       32'd0);
        chk({tag, "_err"},   32'(err),        32'd0);
    endtask

    task automatic fill_random(input int max_lat);
        for (int a = 0; a < N_ADDR; a++) begin
            mem[a] = {$urandom, $urandom, $urandom, $urandom};
            lat[a] = $urandom_range(0, max_lat);
        end
    endtask

    // Runs one sweep; abort_at >= 0 asserts reset once that address is reached
    task automatic run_sweep(input int rmode, input bit timing, input bit poke40,
                             input bit short_too, input int abort_at);
        int  guard;
        bit  poked;
        byte_q.delete();
        exp_err = 1'b0;
        for (int a = 0; a < N_ADDR; a++) begin
            if (lat[a] == NEVER) exp_err = 1'b1;
            for (int b = 0; b < NB; b++)
                byte_q.push_back(lat[a] == NEVER ? 8'h00 : mem[a][8*b +: 8]);
        end
        exp_addr = 0; first_issue = -1; done_cnt = 0; n_bytes = 0; prev_stall = 1'b0;
        ready_mode = rmode; ready_ph = 0; byte_ready = 1'b1;
        if (short_too) begin
            s_cnt = 0; s_done = 0; s_exp_addr = 0; start_s = 1'b1;
        end
        start = 1'b1;
        cycle();
        start = 1'b0; start_s = 1'b0;
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_err_clr", 32'(err), 32'd0);
        chk("start_addr0", 32'(addr_cntrl), 32'd0);
        guard = 0; poked = 1'b0;
        while (done_cnt == 0 && guard < 20000) begin
            if (abort_at >= 0 && busy && addr_cntrl == ADDR_W'(abort_at)) begin
                #2 rst_n = 1'b0;
                #1 check_all_zero("async_rst");
                @(posedge clk); @(posedge clk); #1;
                rst_n = 1'b1; prev_stall = 1'b0; start = 1'b0;
                chk("abort_no_done", 32'(done_cnt), 32'd0);
                return;
            end
            start = poke40 && !poked && busy && (addr_cntrl == ADDR_W'(40));
            if (start) poked = 1'b1;
            cycle();
            guard++;
        end
        start = 1'b0;
        chk("done_seen", 32'(done_cnt), 32'd1);
        if (poke40) chk("poke_reached", 32'(poked), 32'd1);
        repeat (20) cycle();
        chk("done_count", 32'(done_cnt), 32'd1);
        chk("busy_after", 32'(busy), 32'd0);
        chk("err_final", 32'(err), 32'(exp_err));
        chk("byte_count", 32'(n_bytes), 32'd2048);
        chk("issue_count", 32'(exp_addr), 32'd128);
        if (timing) chk("sweep_cycles", 32'(done_cyc - first_issue), 32'd2176);
        if (short_too) begin
            chk("short_bytes", 32'(s_cnt), 32'd64);
            chk("short_done", 32'(s_done), 32'd1);
            chk("short_issues", 32'(s_exp_addr), 32'd4);
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; start_s = 1'b0; byte_ready = 1'b1;
        ready_mode = 0; ready_ph = 0; prev_stall = 1'b0; prev_data = '0;
        exp_addr = 0; first_issue = -1; done_cnt = 0; done_cyc = 0; n_bytes = 0; exp_err = 1'b0;
        s_cnt = 0; s_done = 0; s_exp_addr = 0;
        for (int a = 0; a < N_ADDR; a++) begin mem[a] = '0; lat[a] = 0; end
        repeat (3) @(posedge clk);
        #1 check_all_zero("reset");
        rst_n = 1'b1;
        repeat (2) cycle();

        // Full sweep with fixed pattern, zero latency, no backpressure
        for (int a = 0; a < N_ADDR; a++) begin
            mem[a] = {NB{8'(a) + 8'h10}};
            lat[a] = 0;
        end
        run_sweep(0, 1'b1, 1'b0, 1'b1, -1);

        // Byte order at addr 0, random latency, 1,0,0,1 backpressure, stray
        // Dout_valid outside reads, start poked while busy at addr 40
        fill_random(3);
        for (int b = 0; b < NB; b++) mem[0][8*b +: 8] = 8'(b);
        lat[7] = 3;
        stray_en = 1'b1;
        run_sweep(1, 1'b0, 1'b1, 1'b0, -1);

        // Read timeout at addr 5 with random backpressure
        fill_random(3);
        lat[5] = NEVER;
        run_sweep(2, 1'b0, 1'b0, 1'b0, -1);

        // Reset mid-sweep at addr 60, then a clean restart
        fill_random(2);
        run_sweep(2, 1'b0, 1'b0, 1'b0, 60);
        repeat (3) cycle();
        fill_random(3);
        run_sweep(2, 1'b0, 1'b0, 1'b0, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
